// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types for the processor-to-memory port.
// Also holds the tag-ownership types used by the memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int XLEN             = 32;
    localparam int TAG_W            = 4;
    localparam int NUM_TAGS_DEF     = 16;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } MEM_OWNER;

    typedef struct packed {
        logic     valid;
        MEM_OWNER owner;
        logic     squashed;
    } TAG_ENTRY;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request, response and memory-port signals of the memory bus arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic              fetch_req_valid;
    logic [XLEN-1:0]   fetch_req_addr;
    logic              fetch_ack;
    logic              fetch_flush;
    logic              fetch_resp_valid;
    logic [63:0]       fetch_resp_data;

    logic              data_req_valid;
    BUS_COMMAND        data_req_cmd;
    logic [XLEN-1:0]   data_req_addr;
    logic [63:0]       data_req_data;
    logic              data_ack;
    logic              data_resp_valid;
    logic [63:0]       data_resp_data;
    logic [TAG_W-1:0]  data_resp_tag;
    logic [TAG_W-1:0]  data_issue_tag;

    BUS_COMMAND        proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [TAG_W-1:0]  mem2proc_response;
    logic [63:0]       mem2proc_data;
    logic [TAG_W-1:0]  mem2proc_tag;

    modport slave (
        input  fetch_req_valid, fetch_req_addr, fetch_flush,
        input  data_req_valid, data_req_cmd, data_req_addr, data_req_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output fetch_ack, fetch_resp_valid, fetch_resp_data,
        output data_ack, data_resp_valid, data_resp_data, data_resp_tag, data_issue_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data
    );

    modport master (
        output fetch_req_valid, fetch_req_addr, fetch_flush,
        output data_req_valid, data_req_cmd, data_req_addr, data_req_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  fetch_ack, fetch_resp_valid, fetch_resp_data,
        input  data_ack, data_resp_valid, data_resp_data, data_resp_tag, data_issue_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data
    );

endinterface

// File: rtl/mem_tag_table.sv
// Per-tag owner table: records who issued each outstanding load and whether a
// branch flush has made a fetch load stale.
module mem_tag_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = NUM_TAGS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             allocValid_i,
    input  logic [TAG_W-1:0] allocTag_i,
    input  MEM_OWNER         allocOwner_i,
    input  logic             flush_i,
    input  logic [TAG_W-1:0] lookupTag_i,
    input  logic             freeValid_i,
    output TAG_ENTRY         lookupEntry_o
);

    TAG_ENTRY table_q [NUM_TAGS];
    TAG_ENTRY table_d [NUM_TAGS];

    assign lookupEntry_o = table_q[lookupTag_i];

    // Squash first, then free the returning tag, then allocate, so a tag that
    // is returned and re-issued in the same cycle ends up holding the new load.
    always_comb begin
        table_d = table_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (flush_i && table_q[i].valid && table_q[i].owner == OWNER_FETCH) begin
                table_d[i].squashed = 1'b1;
            end
        end
        if (freeValid_i) begin
            table_d[lookupTag_i] = '0;
        end
        if (allocValid_i) begin
            table_d[allocTag_i].valid    = 1'b1;
            table_d[allocTag_i].owner    = allocOwner_i;
            table_d[allocTag_i].squashed = flush_i && (allocOwner_i == OWNER_FETCH);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            table_q <= table_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between instruction fetch and the LSQ, with a
// starvation guard for fetch, and routes returning load data by tag owner.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS     = NUM_TAGS_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
    logic             fetchWins, dataWins, accepted, fetchAck, dataAck;
    logic             allocValid, retHit;
    MEM_OWNER         allocOwner;
    TAG_ENTRY         retEntry;

    // Data wins by default; fetch takes the port when alone or once starved.
    always_comb begin
        fetchWins  = !reset && bus.fetch_req_valid
                     && (starveCnt_q == STARVE_MAX || !bus.data_req_valid);
        dataWins   = !reset && bus.data_req_valid && !fetchWins;
        accepted   = bus.mem2proc_response != '0;
        fetchAck   = fetchWins && accepted;
        dataAck    = dataWins && accepted;
        allocValid = fetchAck || (dataAck && bus.data_req_cmd == BUS_LOAD);
        allocOwner = fetchAck ? OWNER_FETCH : OWNER_DATA;
    end

    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (fetchWins) begin
            bus.proc2mem_command = BUS_LOAD;
            bus.proc2mem_addr    = bus.fetch_req_addr;
        end else if (dataWins) begin
            bus.proc2mem_command = bus.data_req_cmd;
            bus.proc2mem_addr    = bus.data_req_addr;
            bus.proc2mem_data    = bus.data_req_data;
        end
    end

    always_comb begin
        retHit               = !reset && bus.mem2proc_tag != '0 && retEntry.valid;
        bus.fetch_ack        = fetchAck;
        bus.data_ack         = dataAck;
        bus.data_issue_tag   = dataAck ? bus.mem2proc_response : '0;
        bus.fetch_resp_valid = retHit && retEntry.owner == OWNER_FETCH && !retEntry.squashed;
        bus.data_resp_valid  = retHit && retEntry.owner == OWNER_DATA;
        bus.fetch_resp_data  = bus.fetch_resp_valid ? bus.mem2proc_data : '0;
        bus.data_resp_data   = bus.data_resp_valid ? bus.mem2proc_data : '0;
        bus.data_resp_tag    = bus.data_resp_valid ? bus.mem2proc_tag : '0;
    end

    // A granted-but-rejected fetch neither counts as a loss nor resets the count.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!bus.fetch_req_valid || fetchAck) begin
            starveCnt_d = '0;
        end else if (!fetchWins && starveCnt_q != STARVE_MAX) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

    mem_tag_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tagTable (
        .clock         (clock),
        .reset         (reset),
        .allocValid_i  (allocValid),
        .allocTag_i    (bus.mem2proc_response),
        .allocOwner_i  (allocOwner),
        .flush_i       (bus.fetch_flush),
        .lookupTag_i   (bus.mem2proc_tag),
        .freeValid_i   (retHit),
        .lookupEntry_o (retEntry)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected acks and
// responses, a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    typedef struct {
        MEM_OWNER   owner;
        logic [3:0] tag;
        logic       checkTag;
    } ack_t;

    typedef struct {
        MEM_OWNER    owner;
        logic [63:0] data;
        logic [3:0]  tag;
    } resp_t;

    logic  clock = 1'b0;
    logic  reset;
    ack_t  ackQ[$];
    resp_t respQ[$];
    int    passCount = 0;
    int    checkCount = 0;

    always #5 clock = ~clock;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(
        .NUM_TAGS     (16),
        .STARVE_LIMIT (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic fv, input logic [31:0] fa, input logic fl,
                                 input logic dv, input BUS_COMMAND dc, input logic [31:0] da,
                                 input logic [63:0] dd, input logic [3:0] rsp,
                                 input logic [3:0] rt, input logic [63:0] rd);
        @(posedge clock);
        #1;
        bus.fetch_req_valid   = fv;
        bus.fetch_req_addr    = fa;
        bus.fetch_flush       = fl;
        bus.data_req_valid    = dv;
        bus.data_req_cmd      = dc;
        bus.data_req_addr     = da;
        bus.data_req_data     = dd;
        bus.mem2proc_response = rsp;
        bus.mem2proc_tag      = rt;
        bus.mem2proc_data     = rd;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, BUS_NONE, 0, 0, 0, 0, 0);
    endtask

    task automatic returnTag(input logic [3:0] t, input logic [63:0] d);
        applyStimulus(0, 0, 0, 0, BUS_NONE, 0, 0, 0, t, d);
    endtask

    // Monitor: every ack or response the DUT shows must match the queue head.
    always @(negedge clock) begin
        ack_t  a;
        resp_t r;
        if (bus.fetch_ack || bus.data_ack) begin
            if (ackQ.size() == 0) begin
                checkOutput("unexpected ack", {62'h0, bus.fetch_ack, bus.data_ack}, 64'h0);
            end else begin
                a = ackQ.pop_front();
                checkOutput("ack owner", 64'(bus.data_ack), 64'(a.owner));
                if (a.owner == OWNER_DATA && a.checkTag)
                    checkOutput("issue tag", 64'(bus.data_issue_tag), 64'(a.tag));
            end
        end
        if (bus.fetch_resp_valid || bus.data_resp_valid) begin
            if (respQ.size() == 0) begin
                checkOutput("unexpected resp", 64'(bus.mem2proc_tag), 64'h0);
            end else begin
                r = respQ.pop_front();
                checkOutput("resp owner", 64'(bus.data_resp_valid), 64'(r.owner));
                checkOutput("resp data",
                            bus.data_resp_valid ? bus.data_resp_data : bus.fetch_resp_data, r.data);
                if (r.owner == OWNER_DATA)
                    checkOutput("resp tag", 64'(bus.data_resp_tag), 64'(r.tag));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0] starveTags [6];
        starveTags = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8};

        reset = 1'b1;
        bus.fetch_req_valid = 0; bus.fetch_req_addr = 0; bus.fetch_flush = 0;
        bus.data_req_valid = 0; bus.data_req_cmd = BUS_NONE; bus.data_req_addr = 0;
        bus.data_req_data = 0; bus.mem2proc_response = 0; bus.mem2proc_tag = 0;
        bus.mem2proc_data = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("reset cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
        checkOutput("reset addr", 64'(bus.proc2mem_addr), 64'h0);
        checkOutput("reset acks", {62'h0, bus.fetch_ack, bus.data_ack}, 64'h0);
        checkOutput("reset resp", {62'h0, bus.fetch_resp_valid, bus.data_resp_valid}, 64'h0);

        // Fetch alone, tag 3 returns 0xDEAD, a second return of tag 3 is dropped
        applyStimulus(1, 32'h100, 0, 0, BUS_NONE, 0, 0, 4'd3, 0, 0);
        ackQ.push_back('{OWNER_FETCH, 4'd3, 1'b0});
        @(negedge clock);
        checkOutput("fetch cmd", 64'(bus.proc2mem_command), 64'(BUS_LOAD));
        checkOutput("fetch addr", 64'(bus.proc2mem_addr), 64'h100);
        idleCycle();
        returnTag(4'd3, 64'hDEAD);
        respQ.push_back('{OWNER_FETCH, 64'hDEAD, 4'd3});
        returnTag(4'd3, 64'hBEEF);

        // Starvation: data wins four times, fetch on the fifth, data again after
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 32'h200, 0, 1, BUS_LOAD, 32'h300, 0, starveTags[i], 0, 0);
            ackQ.push_back('{(i == 4) ? OWNER_FETCH : OWNER_DATA, starveTags[i], 1'b1});
            @(negedge clock);
            checkOutput("starve addr", 64'(bus.proc2mem_addr), (i == 4) ? 64'h200 : 64'h300);
        end
        for (int i = 0; i < 6; i++) begin
            returnTag(starveTags[i], 64'h1000 + 64'(starveTags[i]));
            respQ.push_back('{(i == 4) ? OWNER_FETCH : OWNER_DATA,
                              64'h1000 + 64'(starveTags[i]), starveTags[i]});
        end

        // Store on tag 5 allocates nothing, so its return is silent
        applyStimulus(0, 0, 0, 1, BUS_STORE, 32'h400, 64'hCAFE, 4'd5, 0, 0);
        ackQ.push_back('{OWNER_DATA, 4'd5, 1'b0});
        @(negedge clock);
        checkOutput("store cmd", 64'(bus.proc2mem_command), 64'(BUS_STORE));
        checkOutput("store data", bus.proc2mem_data, 64'hCAFE);
        returnTag(4'd5, 64'h5555);
        @(negedge clock);
        checkOutput("store return silent", {62'h0, bus.fetch_resp_valid, bus.data_resp_valid}, 64'h0);

        // Flush: fetch tags 1,2 squashed, tag 9 issued during flush squashed,
        // tag 10 returning during flush delivered, data tag 11 untouched
        applyStimulus(1, 32'h500, 0, 0, BUS_NONE, 0, 0, 4'd1, 0, 0);
        ackQ.push_back('{OWNER_FETCH, 4'd1, 1'b0});
        applyStimulus(1, 32'h508, 0, 0, BUS_NONE, 0, 0, 4'd2, 0, 0);
        ackQ.push_back('{OWNER_FETCH, 4'd2, 1'b0});
        applyStimulus(1, 32'h510, 0, 0, BUS_NONE, 0, 0, 4'd10, 0, 0);
        ackQ.push_back('{OWNER_FETCH, 4'd10, 1'b0});
        applyStimulus(0, 0, 0, 1, BUS_LOAD, 32'h600, 0, 4'd11, 0, 0);
        ackQ.push_back('{OWNER_DATA, 4'd11, 1'b1});
        applyStimulus(1, 32'h518, 1, 0, BUS_NONE, 0, 0, 4'd9, 4'd10, 64'hAAAA);
        ackQ.push_back('{OWNER_FETCH, 4'd9, 1'b0});
        respQ.push_back('{OWNER_FETCH, 64'hAAAA, 4'd10});
        returnTag(4'd1, 64'hBAD);
        returnTag(4'd2, 64'hBAD);
        returnTag(4'd9, 64'hBAD);
        @(negedge clock);
        checkOutput("squashed drop", {63'h0, bus.fetch_resp_valid}, 64'h0);
        returnTag(4'd11, 64'hB11);
        respQ.push_back('{OWNER_DATA, 64'hB11, 4'd11});
        applyStimulus(1, 32'h520, 0, 0, BUS_NONE, 0, 0, 4'd1, 0, 0);
        ackQ.push_back('{OWNER_FETCH, 4'd1, 1'b0});
        returnTag(4'd1, 64'hF00D);
        respQ.push_back('{OWNER_FETCH, 64'hF00D, 4'd1});

        // Memory rejects three times; request stays on the bus until accepted
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h700, 0, 0, BUS_NONE, 0, 0, 4'd0, 0, 0);
            @(negedge clock);
            checkOutput("reject cmd", 64'(bus.proc2mem_command), 64'(BUS_LOAD));
            checkOutput("reject addr", 64'(bus.proc2mem_addr), 64'h700);
        end
        applyStimulus(1, 32'h700, 0, 0, BUS_NONE, 0, 0, 4'd12, 0, 0);
        ackQ.push_back('{OWNER_FETCH, 4'd12, 1'b0});
        returnTag(4'd12, 64'hC0DE);
        respQ.push_back('{OWNER_FETCH, 64'hC0DE, 4'd12});

        // Reset with three loads outstanding; their returns must be dropped
        applyStimulus(1, 32'h800, 0, 0, BUS_NONE, 0, 0, 4'd13, 0, 0);
        ackQ.push_back('{OWNER_FETCH, 4'd13, 1'b0});
        applyStimulus(0, 0, 0, 1, BUS_LOAD, 32'h900, 0, 4'd14, 0, 0);
        ackQ.push_back('{OWNER_DATA, 4'd14, 1'b1});
        applyStimulus(1, 32'h808, 0, 0, BUS_NONE, 0, 0, 4'd15, 0, 0);
        ackQ.push_back('{OWNER_FETCH, 4'd15, 1'b0});
        idleCycle();
        reset = 1'b1;
        idleCycle();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post-reset cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
        checkOutput("post-reset data", bus.proc2mem_data, 64'h0);
        returnTag(4'd13, 64'h13);
        returnTag(4'd14, 64'h14);
        @(negedge clock);
        checkOutput("post-reset drop", {62'h0, bus.fetch_resp_valid, bus.data_resp_valid}, 64'h0);
        returnTag(4'd15, 64'h15);
        idleCycle();
        @(negedge clock);

        checkOutput("acks outstanding", 64'(ackQ.size()), 64'h0);
        checkOutput("resps outstanding", 64'(respQ.size()), 64'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single processor-to-memory port between the instruction-fetch requester and the data (load/store queue) requester. It tracks every outstanding load by memory tag and routes each returning tag's data to the requester that issued it. It drops fetch data that a branch flush has made stale. It sits between the prefetch/fetch stage, the LSQ and the top-level memory interface.

## Interface
- `NUM_TAGS`, 16: memory tag space; tag 0 means "not accepted / no data".
- `STARVE_LIMIT`, 4: consecutive cycles fetch may lose arbitration before it is forced to win.
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `fetch_req_valid` input 1: fetch wants a 64-bit load.
- `fetch_req_addr` input XLEN: 8-byte-aligned fetch address.
- `fetch_ack` output 1: fetch request accepted by memory this cycle.
- `fetch_flush` input 1: taken branch; squash all in-flight fetch loads.
- `fetch_resp_valid` output 1: fetch data returning this cycle.
- `fetch_resp_data` output 64: returned fetch data.
- `data_req_valid` input 1: LSQ request pending.
- `data_req_cmd` input 2: BUS_LOAD or BUS_STORE.
- `data_req_addr` input XLEN: LSQ address.
- `data_req_data` input 64: store data.
- `data_ack` output 1: LSQ request accepted this cycle.
- `data_resp_valid` output 1: load data returning to LSQ.
- `data_resp_data` output 64: returned load data.
- `data_resp_tag` output 4: memory tag of the returning load, used by the LSQ to match its entry.
- `data_issue_tag` output 4: tag assigned to the accepted LSQ load, valid with `data_ack`.
- `proc2mem_command` output 2: BUS_NONE, BUS_LOAD or BUS_STORE.
- `proc2mem_addr` output XLEN; `proc2mem_data` output 64.
- `mem2proc_response` input 4: accept tag, 0 means rejected.
- `mem2proc_data` input 64; `mem2proc_tag` input 4: return tag, 0 means none.

## Operation
- Requesters hold their request stable until they see an ack. Ack = granted && `mem2proc_response` != 0.
- Default priority: the data requester wins.
- Fetch wins when `starve_cnt` == `STARVE_LIMIT` or when no data request is present.
- `starve_cnt`:
  - increments when fetch is valid and not granted;
  - clears on a fetch ack or when fetch is not valid;
  - saturates at `STARVE_LIMIT`.
- Grant is combinational. The winner's cmd, addr and data drive the memory port. With no valid request the port shows BUS_NONE, addr 0, data 0.
- Owner table: `NUM_TAGS` entries of {valid, owner (0 = fetch, 1 = data), squashed}.
- A load ack with nonzero tag T sets entry T to {1, owner, 0}.
- A store ack allocates no entry.
- Return with `mem2proc_tag` T != 0 and entry T valid:
  - owner fetch, not squashed: `fetch_resp_valid` = 1;
  - owner fetch, squashed: the data is dropped;
  - owner data: `data_resp_valid` = 1 and `data_resp_tag` = T.
  - In every case entry T is cleared.
- A return with entry T invalid is dropped silently.
- `fetch_flush` sets `squashed` on every valid fetch-owned entry.
  - A fetch request acked in the same cycle as the flush is also allocated squashed.
  - `fetch_ack` still asserts so the fetch stage retires the request.
- A tag returned and re-issued in the same cycle: the return is processed first, then the allocation; the new entry wins.
- Reset:
  - all table entries invalid; `starve_cnt` = 0;
  - all outputs 0 in the following cycle, with `proc2mem_command` = BUS_NONE;
  - in-flight memory returns after reset are dropped.

## Timing
- Request to ack: 0 cycles (same cycle) when granted and accepted by memory.
- Return routing is combinational from `mem2proc_tag` and the registered table: response valid in the same cycle as the tag.
- Table and counter update on the posedge after the event. A flush affects returns from the next cycle onward.
- A return in the same cycle as `fetch_flush` is still delivered.
- A rejected request (`mem2proc_response` = 0): no ack. The arbiter re-arbitrates next cycle with an updated `starve_cnt`.

## Structure
- BUS_NONE, BUS_LOAD and BUS_STORE come from the existing shared defines.
- Add to the shared package: the `MEM_OWNER` enum (OWNER_FETCH, OWNER_DATA) and a `TAG_ENTRY` struct {valid, owner, squashed}.
- One natural sub-module, `mem_tag_table`: owner table with allocate, lookup/free, and flush-squash ports.
- Priority logic and the starvation counter stay in the top module.

## Test plan
- Fetch only, addr 0x100, memory response 3, later tag 3 with data 0xDEAD → `fetch_ack` in the same cycle; `fetch_resp_valid` = 1 with data 0xDEAD; entry 3 cleared.
- Fetch and LSQ load both valid every cycle, memory always accepts → data wins 4 cycles, fetch acked on the 5th, `starve_cnt` back to 0.
- LSQ store accepted with tag 5, then tag 5 returns → no response valid; table stays empty.
- Fetch loads in flight on tags 1 and 2, `fetch_flush`, tags return → no `fetch_resp_valid`; entries freed; a subsequent fetch on tag 1 returns normally.
- Memory response 0 for 3 cycles → no ack; request is held on the bus; ack on the first nonzero response.
- Reset asserted with 3 loads outstanding, then their tags return → all dropped; outputs 0; BUS_NONE.
